imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// Finds the instruction immediate field that the extend unit expands back to Value.
// Define IMMENC_FAST_SEARCH_EN to evaluate all 16 rotations in a single cycle.
module imm_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [23:0] Extend_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      stateR;
  state_t      nextStateS;
  logic [3:0]  rotR;
  logic [3:0]  nextRotS;
  logic [31:0] valueR;
  logic [31:0] nextValueS;
  logic        validR;
  logic        nextValidS;
  logic [23:0] extR;
  logic [23:0] nextExtS;
  logic        busyR;
  logic        doneR;
  logic [31:0] candS;

  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] dbl;
    dbl = {v, v} << sh;
    return dbl[63:32];
  endfunction

  // Returns {valid, field} for the modes that need no search.
  function automatic logic [24:0] encodeDirect(input logic [1:0] src, input logic [31:0] v);
    logic [24:0] res;
    res = 25'h0;
    case (src)
      2'b01: begin
        if (v[31:12] == 20'h0) begin
          res = {1'b1, 12'h000, v[11:0]};
        end else begin
          res = 25'h0;
        end
      end
      2'b10: begin
        if ((v[1:0] == 2'b00) && ((v[31:25] == 7'h00) || (v[31:25] == 7'h7F))) begin
          res = {1'b1, v[25:2]};
        end else begin
          res = 25'h0;
        end
      end
      default: res = 25'h0;
    endcase
    return res;
  endfunction

`ifdef IMMENC_FAST_SEARCH_EN
  // Walks rotations from 15 down to 0 so the smallest matching one is kept last.
  function automatic logic [24:0] fastRotSearch(input logic [31:0] v);
    logic [24:0] res;
    logic [31:0] cand;
    res = 25'h0;
    for (int r = 15; r >= 0; r--) begin
      cand = rotl32(v, 5'(2 * r));
      if (cand[31:8] == 24'h0) begin
        res = {1'b1, 12'h000, 4'(r), cand[7:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction
`endif

  // Next-state, rotation counter and result computation.
  always_comb begin
    nextStateS = stateR;
    nextRotS   = rotR;
    nextValueS = valueR;
    nextValidS = validR;
    nextExtS   = extR;
    candS      = rotl32(valueR, {rotR, 1'b0});
    case (stateR)
      IDLE: begin
        nextRotS = 4'd0;
        if (start) begin
          nextValueS = Value;
          if (ImmSrc == 2'b00) begin
`ifdef IMMENC_FAST_SEARCH_EN
            {nextValidS, nextExtS} = fastRotSearch(Value);
            nextStateS = DONE;
`else
            nextStateS = SEARCH;
`endif
          end else begin
            {nextValidS, nextExtS} = encodeDirect(ImmSrc, Value);
            nextStateS = DONE;
          end
        end else begin
          nextStateS = IDLE;
        end
      end
      SEARCH: begin
        if (candS[31:8] == 24'h0) begin
          nextValidS = 1'b1;
          nextExtS   = {12'h000, rotR, candS[7:0]};
          nextStateS = DONE;
          nextRotS   = 4'd0;
        end else if (rotR == 4'd15) begin
          // Exhausted without wrapping: report unencodable.
          nextValidS = 1'b0;
          nextExtS   = 24'h0;
          nextStateS = DONE;
          nextRotS   = 4'd0;
        end else begin
          nextRotS = rotR + 4'd1;
        end
      end
      DONE: begin
        nextStateS = IDLE;
        nextRotS   = 4'd0;
      end
      default: begin
        nextStateS = IDLE;
        nextRotS   = 4'd0;
      end
    endcase
  end

  // State, operand and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stateR <= IDLE;
      rotR   <= 4'd0;
      valueR <= 32'h0;
      validR <= 1'b0;
      extR   <= 24'h0;
      busyR  <= 1'b0;
      doneR  <= 1'b0;
    end else begin
      stateR <= nextStateS;
      rotR   <= nextRotS;
      valueR <= nextValueS;
      validR <= nextValidS;
      extR   <= nextExtS;
      busyR  <= (nextStateS != IDLE);
      doneR  <= (nextStateS == DONE);
    end
  end

  assign busy       = busyR;
  assign done       = doneR;
  assign valid      = validR;
  assign Extend_out = extR;

endmodule
